// File: rtl/scc_pkg.sv
// Shared definitions for the event-triggered pulse generator: MMR map,
// channel state encoding and per-channel configuration record.
package scc_pkg;

  localparam int MMR_ADDR_W = 12;
  localparam int MMR_DATA_W = 32;
  localparam int EV_W       = 8;

  localparam int DLY_W = 16;
  localparam int WID_W = 8;
  localparam int PRD_W = 16;
  // Shared down-counter; must cover the widest of DLY/WID/PRD.
  localparam int CNT_W     = 16;
  localparam int CFG_MAX_W = 16;

  localparam logic [MMR_ADDR_W-1:0] REG_CR        = 12'h000;
  localparam logic [MMR_ADDR_W-1:0] REG_SR        = 12'h004;
  localparam logic [MMR_ADDR_W-1:0] REG_FORCE     = 12'h008;
  localparam logic [MMR_ADDR_W-1:0] REG_IRQ_MSK   = 12'h00C;
  localparam logic [MMR_ADDR_W-1:0] REG_CH_BASE   = 12'h010;
  localparam logic [MMR_ADDR_W-1:0] REG_CH_STRIDE = 12'h010;
  localparam logic [MMR_ADDR_W-1:0] OFF_EV        = 12'h000;
  localparam logic [MMR_ADDR_W-1:0] OFF_DLY       = 12'h004;
  localparam logic [MMR_ADDR_W-1:0] OFF_WID       = 12'h008;
  localparam logic [MMR_ADDR_W-1:0] OFF_PRD       = 12'h00C;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_PULSE,
    ST_REPEAT
  } ch_state_e;

  typedef struct packed {
    logic [EV_W-1:0]  ev;
    logic [DLY_W-1:0] dly;
    logic [WID_W-1:0] wid;
    logic [PRD_W-1:0] prd;
  } ch_cfg_t;

  // Byte address of a channel register.
  function automatic logic [MMR_ADDR_W-1:0] ch_addr(input int c,
                                                    input logic [MMR_ADDR_W-1:0] off);
    return REG_CH_BASE + REG_CH_STRIDE * MMR_ADDR_W'(c) + off;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-lite register access bundle (no wstrb/prot: all writes are full-word).
interface axi4_lite_if
  import scc_pkg::*;
#(
  parameter int ADDR_W = MMR_ADDR_W,
  parameter int DATA_W = MMR_DATA_W
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport m (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport s (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/evt_pulse_ch.sv
// One pulse channel: trigger qualification, shadow config, delay/pulse/repeat
// sequencing. Optional macro EVT_PULSE_GEN_RETRIG_EN lets a trigger restart a
// running channel instead of flagging an overrun.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | waiting for a trigger
//   ST_DELAY  | counting down the trigger-to-pulse delay
//   ST_PULSE  | pulse asserted, counting down the width
//   ST_REPEAT | periodic mode, counting down the gap to next pulse
module evt_pulse_ch
  import scc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sw_trig,
  input  logic [EV_W-1:0] ev,
  input  ch_cfg_t         cfg,
  output logic            pulse,
  output logic            busy,
  output logic            ovr
);

`ifdef EVT_PULSE_GEN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WID_W-1:0] wid_s, wid_n;
  logic [PRD_W-1:0] prd_s, prd_n;
  logic             go;

  // A zero width makes the trigger a no-op, so it can never overrun either.
  assign go = en & (cfg.wid != '0) &
              (((cfg.ev != '0) & (ev == cfg.ev)) | sw_trig);

  // State, counter, shadows and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      wid_s <= '0;
      prd_s <= '0;
      pulse <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wid_s <= wid_n;
      prd_s <= prd_n;
      pulse <= (state_n == ST_PULSE);
      busy  <= (state_n == ST_DELAY) || (state_n == ST_PULSE);
    end
  end

  // Next state: counters load N-1 so a load of N spans exactly N cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wid_n   = wid_s;
    prd_n   = prd_s;
    ovr     = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else if (go && ((state == ST_IDLE) || RETRIG)) begin
      wid_n = cfg.wid;
      prd_n = cfg.prd;
      if (cfg.dly == '0) begin
        state_n = ST_PULSE;
        cnt_n   = CNT_W'(cfg.wid) - ONE;
      end else begin
        state_n = ST_DELAY;
        cnt_n   = CNT_W'(cfg.dly) - ONE;
      end
    end else begin
      ovr = go;
      case (state)
        ST_IDLE: ;
        ST_DELAY: begin
          if (cnt == '0) begin
            state_n = ST_PULSE;
            cnt_n   = CNT_W'(wid_s) - ONE;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
        ST_PULSE: begin
          if (cnt != '0) begin
            cnt_n = cnt - ONE;
          end else if (prd_s == '0) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_REPEAT;
            cnt_n   = CNT_W'(prd_s) - ONE;
          end
        end
        ST_REPEAT: begin
          if (cnt == '0) begin
            state_n = ST_PULSE;
            cnt_n   = CNT_W'(wid_s) - ONE;
          end else begin
            cnt_n = cnt - ONE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/evt_pulse_gen.sv
// N-channel event-triggered pulse generator: AXI4-lite register block,
// global CR/SR/FORCE/IRQ_MSK and the channel array. Build option
// EVT_PULSE_GEN_RETRIG_EN selects restart-on-retrigger in the channels.
module evt_pulse_gen
  import scc_pkg::*;
#(
  parameter int N_CH = 4
)
(
  input  logic            clk,
  input  logic            rst,
  axi4_lite_if.s          mmr,
  input  logic [EV_W-1:0] ev,
  output logic [N_CH-1:0] pulse_out,
  output logic [N_CH-1:0] busy,
  output logic            irq
);

  logic                  aw_held, w_held;
  logic [MMR_ADDR_W-1:0] aw_addr;
  logic [MMR_DATA_W-1:0] w_data;
  logic                  aw_hs, w_hs, b_hs, ar_hs;
  logic                  wr_cr, wr_sr, wr_force, wr_msk;
  logic [N_CH-1:0]       wr_ev, wr_dly, wr_wid, wr_prd;
  logic [N_CH-1:0]       cr, sr, irq_msk, sw_trig, ovr;
  ch_cfg_t               cfg [N_CH];
  logic [MMR_DATA_W-1:0] rd_data;
  logic                  unused_wdata;

  assign aw_hs = mmr.awvalid & mmr.awready;
  assign w_hs  = mmr.wvalid & mmr.wready;
  assign b_hs  = mmr.bvalid & mmr.bready;
  assign ar_hs = mmr.arvalid & mmr.arready;

  assign mmr.bresp = RESP_OKAY;
  assign mmr.rresp = RESP_OKAY;

  // Write channel: AW and W captured independently, one write outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr     <= '0;
      w_data      <= '0;
      mmr.awready <= 1'b0;
      mmr.wready  <= 1'b0;
      mmr.bvalid  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= mmr.awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= mmr.wdata;
      end
      if (b_hs) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        mmr.bvalid <= 1'b0;
      end else if (aw_held && w_held) begin
        mmr.bvalid <= 1'b1;
      end
      mmr.awready <= ~((aw_held | aw_hs) & ~b_hs);
      mmr.wready  <= ~((w_held | w_hs) & ~b_hs);
    end
  end

  // Write decode; registers commit on the B handshake.
  always_comb begin
    wr_cr    = 1'b0;
    wr_sr    = 1'b0;
    wr_force = 1'b0;
    wr_msk   = 1'b0;
    wr_ev    = '0;
    wr_dly   = '0;
    wr_wid   = '0;
    wr_prd   = '0;
    if (b_hs) begin
      wr_cr    = (aw_addr == REG_CR);
      wr_sr    = (aw_addr == REG_SR);
      wr_force = (aw_addr == REG_FORCE);
      wr_msk   = (aw_addr == REG_IRQ_MSK);
      for (int c = 0; c < N_CH; c++) begin
        wr_ev[c]  = (aw_addr == ch_addr(c, OFF_EV));
        wr_dly[c] = (aw_addr == ch_addr(c, OFF_DLY));
        wr_wid[c] = (aw_addr == ch_addr(c, OFF_WID));
        wr_prd[c] = (aw_addr == ch_addr(c, OFF_PRD));
      end
    end
  end

  // FORCE is never stored: it is a one-cycle trigger strobe.
  assign sw_trig = wr_force ? w_data[N_CH-1:0] : '0;

  // Configuration and status registers; a new overrun beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cr      <= '0;
      sr      <= '0;
      irq_msk <= '0;
      for (int c = 0; c < N_CH; c++) cfg[c] <= '0;
    end else begin
      if (wr_cr)  cr      <= w_data[N_CH-1:0];
      if (wr_msk) irq_msk <= w_data[N_CH-1:0];
      sr <= (wr_sr ? (sr & ~w_data[N_CH-1:0]) : sr) | ovr;
      for (int c = 0; c < N_CH; c++) begin
        if (wr_ev[c])  cfg[c].ev  <= w_data[EV_W-1:0];
        if (wr_dly[c]) cfg[c].dly <= w_data[DLY_W-1:0];
        if (wr_wid[c]) cfg[c].wid <= w_data[WID_W-1:0];
        if (wr_prd[c]) cfg[c].prd <= w_data[PRD_W-1:0];
      end
    end
  end

  assign unused_wdata = ^w_data[MMR_DATA_W-1:CFG_MAX_W];

  // Read mux; unmapped addresses and FORCE read as zero.
  always_comb begin
    rd_data = '0;
    if (mmr.araddr == REG_CR)      rd_data[N_CH-1:0] = cr;
    if (mmr.araddr == REG_SR)      rd_data[N_CH-1:0] = sr;
    if (mmr.araddr == REG_IRQ_MSK) rd_data[N_CH-1:0] = irq_msk;
    for (int c = 0; c < N_CH; c++) begin
      if (mmr.araddr == ch_addr(c, OFF_EV))  rd_data[EV_W-1:0]  = cfg[c].ev;
      if (mmr.araddr == ch_addr(c, OFF_DLY)) rd_data[DLY_W-1:0] = cfg[c].dly;
      if (mmr.araddr == ch_addr(c, OFF_WID)) rd_data[WID_W-1:0] = cfg[c].wid;
      if (mmr.araddr == ch_addr(c, OFF_PRD)) rd_data[PRD_W-1:0] = cfg[c].prd;
    end
  end

  // Read channel: data registered at AR handshake, one read outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmr.arready <= 1'b0;
      mmr.rvalid  <= 1'b0;
      mmr.rdata   <= '0;
    end else begin
      if (ar_hs) begin
        mmr.rvalid <= 1'b1;
        mmr.rdata  <= rd_data;
      end else if (mmr.rvalid && mmr.rready) begin
        mmr.rvalid <= 1'b0;
      end
      mmr.arready <= ~(ar_hs | (mmr.rvalid & ~mmr.rready));
    end
  end

  assign irq = |(sr & irq_msk);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    evt_pulse_ch u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (cr[c]),
      .sw_trig (sw_trig[c]),
      .ev      (ev),
      .cfg     (cfg[c]),
      .pulse   (pulse_out[c]),
      .busy    (busy[c]),
      .ovr     (ovr[c])
    );
  end

endmodule
